// File: rtl/conv2.sv
// conv2: second convolution stage. Convolves the latched IN_CHxIN_DIMxIN_DIM pooled
// maps with OUT_CH KxK kernels using one signed multiply-accumulate unit, one kernel
// tap per cycle, and writes saturated fixed-point pixels one at a time.
// Build option: define RELU_EN to clamp negative stored results to zero.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for enable
// READ  | latch feature maps, weights and bias
// ACK   | acknowledge upstream, preload accumulator with bias[0]
// MAC   | accumulate one kernel tap per cycle
// STORE | write saturated pixel, preload next pixel's bias
// DONE  | featuremap2 valid and held until downstream replies
module conv2 #(
  parameter int bitwidth = 32,
  parameter int FRAC     = 16,
  parameter int IN_CH    = 2,
  parameter int IN_DIM   = 14,
  parameter int K        = 5,
  parameter int OUT_CH   = 4
) (
  input  logic                                                   clk,
  input  logic                                                   reset,
  input  logic                                                   enable,
  input  logic [IN_CH*IN_DIM*IN_DIM*bitwidth-1:0]                featuremap1_maxpooled,
  input  logic [OUT_CH*IN_CH*K*K*bitwidth-1:0]                   weights2,
  input  logic [OUT_CH*bitwidth-1:0]                             bias2,
  input  logic                                                   reply_from_next_device,
  output logic [OUT_CH*(IN_DIM-K+1)*(IN_DIM-K+1)*bitwidth-1:0]   featuremap2,
  output logic                                                   finished_for_next_device,
  output logic                                                   reply_to_last_device
);

  localparam int OUT_DIM = IN_DIM - K + 1;
  localparam int ACCW    = 2 * bitwidth + 8;
  localparam int MW      = 2 * bitwidth;
  localparam int CW      = (IN_CH > 1) ? $clog2(IN_CH) : 1;
  localparam int OW      = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;
  localparam int DW      = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
  localparam int PW      = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam int KW      = (K > 1) ? $clog2(K) : 1;

  localparam logic [CW-1:0] C_LAST = CW'(IN_CH - 1);
  localparam logic [OW-1:0] O_LAST = OW'(OUT_CH - 1);
  localparam logic [PW-1:0] P_LAST = PW'(OUT_DIM - 1);
  localparam logic [KW-1:0] K_LAST = KW'(K - 1);

  localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-bitwidth+1){1'b0}}, {(bitwidth-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-bitwidth+1){1'b1}}, {(bitwidth-1){1'b0}}};

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_ACK   = 3'd2;
  localparam logic [2:0] S_MAC   = 3'd3;
  localparam logic [2:0] S_STORE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0] state;

  logic signed [bitwidth-1:0] fm_q [IN_CH][IN_DIM][IN_DIM];
  logic signed [bitwidth-1:0] w_q  [OUT_CH][IN_CH][K][K];
  logic signed [bitwidth-1:0] b_q  [OUT_CH];
  logic        [bitwidth-1:0] out_q [OUT_CH][OUT_DIM][OUT_DIM];

  logic [CW-1:0] c_cnt;
  logic [KW-1:0] ki_cnt, kj_cnt;
  logic [OW-1:0] o_cnt;
  logic [PW-1:0] i_cnt, j_cnt;

  logic signed [ACCW-1:0]     acc;
  logic [DW-1:0]              row, col;
  logic signed [MW-1:0]       prod;
  logic signed [ACCW-1:0]     prod_ext;
  logic                       ij_last, px_last, tap_last;
  logic [OW-1:0]              o_next;
  logic signed [bitwidth-1:0] bias_sel;
  logic signed [ACCW-1:0]     bias_acc;
  logic signed [ACCW-1:0]     sh;
  logic [bitwidth-1:0]        pix_val;

  // MAC operand fetch, bias preload selection and store-value saturation
  always_comb begin
    row      = DW'(i_cnt) + DW'(ki_cnt);
    col      = DW'(j_cnt) + DW'(kj_cnt);
    prod     = MW'(fm_q[c_cnt][row][col]) * MW'(w_q[o_cnt][c_cnt][ki_cnt][kj_cnt]);
    prod_ext = {{(ACCW-MW){prod[MW-1]}}, prod};
    tap_last = (c_cnt == C_LAST) && (ki_cnt == K_LAST) && (kj_cnt == K_LAST);
    ij_last  = (i_cnt == P_LAST) && (j_cnt == P_LAST);
    px_last  = ij_last && (o_cnt == O_LAST);
    o_next   = o_cnt;
    if (ij_last) o_next = (o_cnt == O_LAST) ? '0 : o_cnt + OW'(1);
    bias_sel = (state == S_ACK) ? b_q[0] : b_q[o_next];
    bias_acc = ACCW'(bias_sel) <<< FRAC;
    sh       = acc >>> FRAC;
    if (sh > SAT_MAX)      pix_val = {1'b0, {(bitwidth-1){1'b1}}};
    else if (sh < SAT_MIN) pix_val = {1'b1, {(bitwidth-1){1'b0}}};
    else                   pix_val = sh[bitwidth-1:0];
`ifdef RELU_EN
    if (pix_val[bitwidth-1]) pix_val = '0;
`endif
  end

  // Sequencer: state, tap/pixel counters and accumulator
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      acc    <= '0;
      c_cnt  <= '0;
      ki_cnt <= '0;
      kj_cnt <= '0;
      o_cnt  <= '0;
      i_cnt  <= '0;
      j_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: if (enable) state <= S_READ;
        S_READ: state <= S_ACK;
        S_ACK: begin
          acc    <= bias_acc;
          c_cnt  <= '0;
          ki_cnt <= '0;
          kj_cnt <= '0;
          o_cnt  <= '0;
          i_cnt  <= '0;
          j_cnt  <= '0;
          state  <= S_MAC;
        end
        S_MAC: begin
          acc <= acc + prod_ext;
          if (kj_cnt == K_LAST) begin
            kj_cnt <= '0;
            if (ki_cnt == K_LAST) begin
              ki_cnt <= '0;
              if (c_cnt == C_LAST) c_cnt <= '0;
              else                 c_cnt <= c_cnt + CW'(1);
            end else begin
              ki_cnt <= ki_cnt + KW'(1);
            end
          end else begin
            kj_cnt <= kj_cnt + KW'(1);
          end
          if (tap_last) state <= S_STORE;
        end
        S_STORE: begin
          acc   <= bias_acc;
          o_cnt <= o_next;
          if (i_cnt == P_LAST) begin
            i_cnt <= '0;
            if (j_cnt == P_LAST) j_cnt <= '0;
            else                 j_cnt <= j_cnt + PW'(1);
          end else begin
            i_cnt <= i_cnt + PW'(1);
          end
          state <= px_last ? S_DONE : S_MAC;
        end
        S_DONE: begin
          if (finished_for_next_device && reply_from_next_device)
            state <= enable ? S_READ : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Handshake flags; finished rises on the first DONE cycle and drops on reply
  always_ff @(posedge clk) begin
    if (reset) begin
      reply_to_last_device     <= 1'b0;
      finished_for_next_device <= 1'b0;
    end else begin
      reply_to_last_device <= (state == S_ACK);
      if (state == S_DONE) begin
        if (!finished_for_next_device)    finished_for_next_device <= 1'b1;
        else if (reply_from_next_device)  finished_for_next_device <= 1'b0;
      end else begin
        finished_for_next_device <= 1'b0;
      end
    end
  end

  // Input capture; upstream may change its buses once READ has passed
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < IN_CH; c++)
        for (int i = 0; i < IN_DIM; i++)
          for (int j = 0; j < IN_DIM; j++)
            fm_q[c][i][j] <= '0;
      for (int o = 0; o < OUT_CH; o++) begin
        b_q[o] <= '0;
        for (int c = 0; c < IN_CH; c++)
          for (int ki = 0; ki < K; ki++)
            for (int kj = 0; kj < K; kj++)
              w_q[o][c][ki][kj] <= '0;
      end
    end else if (state == S_READ) begin
      for (int c = 0; c < IN_CH; c++)
        for (int i = 0; i < IN_DIM; i++)
          for (int j = 0; j < IN_DIM; j++)
            fm_q[c][i][j] <= featuremap1_maxpooled[((c*IN_DIM+j)*IN_DIM+i)*bitwidth +: bitwidth];
      for (int o = 0; o < OUT_CH; o++) begin
        b_q[o] <= bias2[o*bitwidth +: bitwidth];
        for (int c = 0; c < IN_CH; c++)
          for (int ki = 0; ki < K; ki++)
            for (int kj = 0; kj < K; kj++)
              w_q[o][c][ki][kj] <= weights2[(((o*IN_CH+c)*K+kj)*K+ki)*bitwidth +: bitwidth];
      end
    end
  end

  // Output pixel register file, written once per STORE
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int o = 0; o < OUT_CH; o++)
        for (int i = 0; i < OUT_DIM; i++)
          for (int j = 0; j < OUT_DIM; j++)
            out_q[o][i][j] <= '0;
    end else if (state == S_STORE) begin
      out_q[o_cnt][i_cnt][j_cnt] <= pix_val;
    end
  end

  for (genvar o = 0; o < OUT_CH; o++) begin : g_o
    for (genvar i = 0; i < OUT_DIM; i++) begin : g_i
      for (genvar j = 0; j < OUT_DIM; j++) begin : g_j
        assign featuremap2[((o*OUT_DIM+j)*OUT_DIM+i)*bitwidth +: bitwidth] = out_q[o][i][j];
      end
    end
  end

endmodule

// File: tb/tb_conv2.sv
// tb_conv2: directed frames against a plain-arithmetic convolution model, with a
// per-cycle comparison of featuremap2 while finished_for_next_device is high.
module tb_conv2;

  localparam int BW   = 32;
  localparam int ICH  = 2;
  localparam int ID   = 14;
  localparam int KK   = 5;
  localparam int OCH  = 4;
  localparam int OD   = ID - KK + 1;
  localparam int FMW  = ICH*ID*ID*BW;
  localparam int WW   = OCH*ICH*KK*KK*BW;
  localparam int BBW  = OCH*BW;
  localparam int OUTW = OCH*OD*OD*BW;
  localparam int LAT  = 20403;

  logic            clk;
  logic            reset;
  logic            enable;
  logic [FMW-1:0]  fm_in;
  logic [WW-1:0]   w_in;
  logic [BBW-1:0]  b_in;
  logic            reply_in;
  logic [OUTW-1:0] featuremap2;
  logic            finished_for_next_device;
  logic            reply_to_last_device;

  conv2 dut (
    .clk                      (clk),
    .reset                    (reset),
    .enable                   (enable),
    .featuremap1_maxpooled    (fm_in),
    .weights2                 (w_in),
    .bias2                    (b_in),
    .reply_from_next_device   (reply_in),
    .featuremap2              (featuremap2),
    .finished_for_next_device (finished_for_next_device),
    .reply_to_last_device     (reply_to_last_device)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int in_m  [ICH][ID][ID];
  int w_m   [OCH][ICH][KK][KK];
  int b_m   [OCH];
  int exp_arr [OCH][OD][OD];
  logic [OUTW-1:0] exp_fm;
  bit   exp_ready;
  int   checks;
  int   errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, expv);
    end
  endtask

  function automatic logic [31:0] get_px(input int o, input int i, input int j);
    return featuremap2[((o*OD+j)*OD+i)*BW +: BW];
  endfunction

  task automatic pack_inputs();
    for (int c = 0; c < ICH; c++)
      for (int i = 0; i < ID; i++)
        for (int j = 0; j < ID; j++)
          fm_in[((c*ID+j)*ID+i)*BW +: BW] = in_m[c][i][j];
    for (int o = 0; o < OCH; o++) begin
      b_in[o*BW +: BW] = b_m[o];
      for (int c = 0; c < ICH; c++)
        for (int ki = 0; ki < KK; ki++)
          for (int kj = 0; kj < KK; kj++)
            w_in[(((o*ICH+c)*KK+kj)*KK+ki)*BW +: BW] = w_m[o][c][ki][kj];
    end
  endtask

  // Reference: direct convolution in wide signed arithmetic, then shift, clamp, optional ReLU
  task automatic compute_model();
    logic signed [79:0] acc;
    logic signed [79:0] sh;
    int r;
    for (int o = 0; o < OCH; o++)
      for (int i = 0; i < OD; i++)
        for (int j = 0; j < OD; j++) begin
          acc = b_m[o];
          acc = acc <<< 16;
          for (int c = 0; c < ICH; c++)
            for (int ki = 0; ki < KK; ki++)
              for (int kj = 0; kj < KK; kj++)
                acc = acc + (longint'(in_m[c][i+ki][j+kj]) * longint'(w_m[o][c][ki][kj]));
          sh = acc >>> 16;
          if (sh > 80'sd2147483647)       r = 32'h7FFF_FFFF;
          else if (sh < -80'sd2147483648) r = 32'h8000_0000;
          else                            r = int'(sh[31:0]);
`ifdef RELU_EN
          if (r < 0) r = 0;
`endif
          exp_arr[o][i][j] = r;
          exp_fm[((o*OD+j)*OD+i)*BW +: BW] = r;
        end
    exp_ready = 1'b1;
  endtask

  task automatic set_ones();
    for (int c = 0; c < ICH; c++)
      for (int i = 0; i < ID; i++)
        for (int j = 0; j < ID; j++)
          in_m[c][i][j] = 32'h0001_0000;
    for (int o = 0; o < OCH; o++) begin
      b_m[o] = 0;
      for (int c = 0; c < ICH; c++)
        for (int ki = 0; ki < KK; ki++)
          for (int kj = 0; kj < KK; kj++)
            w_m[o][c][ki][kj] = 32'h0001_0000;
    end
  endtask

  task automatic set_tap();
    for (int c = 0; c < ICH; c++)
      for (int i = 0; i < ID; i++)
        for (int j = 0; j < ID; j++)
          in_m[c][i][j] = (c*196 + j*14 + i) << 16;
    for (int o = 0; o < OCH; o++) begin
      b_m[o] = 0;
      for (int c = 0; c < ICH; c++)
        for (int ki = 0; ki < KK; ki++)
          for (int kj = 0; kj < KK; kj++)
            w_m[o][c][ki][kj] = 0;
    end
    w_m[1][0][2][3] = 32'h0002_0000;
    b_m[1] = 32'hFFFF_0000;
  endtask

  // Channels 0,1 use +max weights, channels 2,3 the negated weights
  task automatic set_sat();
    for (int c = 0; c < ICH; c++)
      for (int i = 0; i < ID; i++)
        for (int j = 0; j < ID; j++)
          in_m[c][i][j] = 32'h7FFF_0000;
    for (int o = 0; o < OCH; o++) begin
      b_m[o] = 0;
      for (int c = 0; c < ICH; c++)
        for (int ki = 0; ki < KK; ki++)
          for (int kj = 0; kj < KK; kj++)
            w_m[o][c][ki][kj] = (o < 2) ? 32'h7FFF_0000 : 32'h8001_0000;
    end
  endtask

  // Per-cycle comparison of the held result against the model
  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (exp_ready && finished_for_next_device === 1'b1) begin
        checks++;
        if (featuremap2 !== exp_fm) begin
          errors++;
          for (int k = 0; k < OCH*OD*OD; k++) begin
            if (featuremap2[k*BW +: BW] !== exp_fm[k*BW +: BW]) begin
              $display("FAIL fm2_vs_model flat_px=%0d actual=%h required=%h",
                       k, featuremap2[k*BW +: BW], exp_fm[k*BW +: BW]);
              break;
            end
          end
        end
      end
    end
  endtask

  // Start a frame (from IDLE, or back-to-back from DONE) and time reply/finished
  task automatic run_frame(input bit b2b, input bit disturb, input string tag);
    int n, rep_cnt, rep_edge, fin_edge;
    @(negedge clk);
    enable = 1'b1;
    if (b2b) reply_in = 1'b1;
    @(posedge clk);
    #1;
    reply_in = 1'b0;
    if (!disturb) enable = 1'b0;
    if (b2b) check({tag, "_fin_drop_on_reply"}, {31'd0, finished_for_next_device}, 32'd0);
    compute_model();
    n = 0; rep_cnt = 0; rep_edge = -1; fin_edge = -1;
    while (n < LAT + 600 && fin_edge < 0) begin
      @(posedge clk);
      n++;
      #1;
      if (reply_to_last_device) begin
        rep_cnt++;
        if (rep_edge < 0) rep_edge = n;
      end
      if (finished_for_next_device) fin_edge = n;
      if (disturb) begin
        if (n == 3) begin
          fm_in = '0;
          w_in  = '0;
        end
        if (n == 8)    enable = 1'b0;
        if (n == 1000) reply_in = 1'b1;
        if (n == 1001) reply_in = 1'b0;
      end
    end
    check({tag, "_reply_cycles"}, rep_cnt, 32'd1);
    check({tag, "_reply_edge"}, rep_edge, 32'd2);
    check({tag, "_finish_edge"}, fin_edge, LAT);
  endtask

  initial begin
    int hold_ok;
    checks = 0; errors = 0; exp_ready = 1'b0;
    reset = 1'b1; enable = 1'b0; reply_in = 1'b0;
    fm_in = '0; w_in = '0; b_in = '0; exp_fm = '0;
    fork
      compare_loop();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("rst_finished", {31'd0, finished_for_next_device}, 32'd0);
    check("rst_reply", {31'd0, reply_to_last_device}, 32'd0);
    check("rst_fm2_zero", {31'd0, featuremap2 == '0}, 32'd1);
    @(negedge clk);
    reset = 1'b0;

    // Abort a running frame roughly 5000 cycles into MAC
    set_ones();
    pack_inputs();
    @(negedge clk);
    enable = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b0;
    repeat (5003) @(posedge clk);
    #1;
    check("abort_pre_px0", get_px(0, 0, 0), 32'h0032_0000);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_fm2_zero", {31'd0, featuremap2 == '0}, 32'd1);
    check("abort_finished", {31'd0, finished_for_next_device}, 32'd0);
    check("abort_reply", {31'd0, reply_to_last_device}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Frame A: all ones; noisy enable/reply and input changes after the ack
    run_frame(1'b0, 1'b1, "ones");
    check("model_ones_000", exp_arr[0][0][0], 32'h0032_0000);
    check("model_ones_399", exp_arr[3][9][9], 32'h0032_0000);
    check("ones_px_0_0_0", get_px(0, 0, 0), 32'h0032_0000);
    check("ones_px_2_7_4", get_px(2, 7, 4), 32'h0032_0000);
    check("ones_px_3_9_9", get_px(3, 9, 9), 32'h0032_0000);
    hold_ok = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (finished_for_next_device) hold_ok++;
    end
    check("hold_finished_cycles", hold_ok, 32'd100);
    @(negedge clk);
    reply_in = 1'b1;
    enable   = 1'b0;
    @(posedge clk);
    #1;
    reply_in = 1'b0;
    check("release_finished", {31'd0, finished_for_next_device}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("idle_finished", {31'd0, finished_for_next_device}, 32'd0);
    check("idle_reply", {31'd0, reply_to_last_device}, 32'd0);

    // Frame B: single tap w[1][0][2][3]=2.0, bias[1]=-1.0
    set_tap();
    pack_inputs();
    run_frame(1'b0, 1'b0, "tap");
    check("model_tap_1_0_0", exp_arr[1][0][0], 32'h0057_0000);
    check("model_tap_1_9_9", exp_arr[1][9][9], 32'h0165_0000);
    check("tap_px_1_0_0", get_px(1, 0, 0), 32'h0057_0000);
    check("tap_px_1_4_0", get_px(1, 4, 0), 32'h005F_0000);
    check("tap_px_1_9_9", get_px(1, 9, 9), 32'h0165_0000);
    check("tap_px_0_5_5", get_px(0, 5, 5), 32'h0000_0000);
    check("tap_px_3_0_0", get_px(3, 0, 0), 32'h0000_0000);

    // Frame C back-to-back: saturation both ways
    set_sat();
    pack_inputs();
    run_frame(1'b1, 1'b0, "sat");
    check("model_sat_pos", exp_arr[0][3][3], 32'h7FFF_FFFF);
    check("sat_px_0_0_0", get_px(0, 0, 0), 32'h7FFF_FFFF);
    check("sat_px_1_9_9", get_px(1, 9, 9), 32'h7FFF_FFFF);
`ifdef RELU_EN
    check("model_sat_neg", exp_arr[2][0][0], 32'h0000_0000);
    check("sat_px_2_0_0", get_px(2, 0, 0), 32'h0000_0000);
    check("sat_px_3_9_9", get_px(3, 9, 9), 32'h0000_0000);
`else
    check("model_sat_neg", exp_arr[2][0][0], 32'h8000_0000);
    check("sat_px_2_0_0", get_px(2, 0, 0), 32'h8000_0000);
    check("sat_px_3_9_9", get_px(3, 9, 9), 32'h8000_0000);
`endif
    @(negedge clk);
    reply_in = 1'b1;
    @(posedge clk);
    #1;
    reply_in = 1'b0;
    check("final_release", {31'd0, finished_for_next_device}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
